sa_cache_miss_ctrl: RTL and testbench

Miss-handling sequencer for the 4-way set-associative cache. On a cache miss it writes back a dirty victim line to backing memory in bus-width beats, fetches the missing line, assembles it, and presents it to the cache for a single-cycle fill. It sits between the cache's miss/victim outputs and the memory bus. The cache itself selects the victim way.

---
 rtl/sa_cache_pkg.sv | 25 ++
 rtl/sa_cache_miss_ctrl_line_beat_buffer.sv | 39 +++
 rtl/sa_cache_miss_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sa_cache_miss_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_cache_pkg.sv
// rtl/sa_cache_pkg.sv - shared cache geometry, derived line/beat sizes and miss FSM states
//   Provides default field widths for the 4-way set-associative cache, the derived
//   line/beat sizes, and the miss-sequencer state enum.
package sa_cache_pkg;

  localparam int SA_ADDRESS_WIDTH   = 32;
  localparam int SA_TAG_BITS        = 18;
  localparam int SA_INDEX_BITS      = 8;
  localparam int SA_OFFSET_BITS     = 6;
  localparam int SA_LINE_SIZE_BYTES = 64;
  localparam int SA_MEM_BUS_BYTES   = 8;

  localparam int LINE_SIZE_BITS = SA_LINE_SIZE_BYTES * 8;
  localparam int BEATS          = SA_LINE_SIZE_BYTES / SA_MEM_BUS_BYTES;
  localparam int BEAT_CNT_W     = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_FILL
  } miss_state_t;

endpackage

// File: rtl/sa_cache_miss_ctrl_line_beat_buffer.sv
// rtl/sa_cache_miss_ctrl_line_beat_buffer.sv - line buffer with whole-line load, beat write and beat read
//   Ports: clk, rst (async, active-high); load_en/load_line capture a full line;
//   wr_en/wr_idx/wr_data write one beat slot; rd_idx/rd_data read one beat;
//   line presents the whole buffer. Load has priority over a beat write.
module line_beat_buffer
  import sa_cache_pkg::*;
#(
  parameter int N_BEATS   = BEATS,
  parameter int BEAT_BITS = SA_MEM_BUS_BYTES * 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_en,
  input  logic [N_BEATS*BEAT_BITS-1:0]   load_line,
  input  logic                           wr_en,
  input  logic [$clog2(N_BEATS)-1:0]     wr_idx,
  input  logic [BEAT_BITS-1:0]           wr_data,
  input  logic [$clog2(N_BEATS)-1:0]     rd_idx,
  output logic [BEAT_BITS-1:0]           rd_data,
  output logic [N_BEATS*BEAT_BITS-1:0]   line
);

  logic [N_BEATS*BEAT_BITS-1:0] line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q[wr_idx*BEAT_BITS +: BEAT_BITS] <= wr_data;
    end
  end

  // Beat 0 occupies the least significant bits of the line.
  assign rd_data = line_q[rd_idx*BEAT_BITS +: BEAT_BITS];
  assign line    = line_q;

endmodule

// File: rtl/sa_cache_miss_ctrl.sv
// rtl/sa_cache_miss_ctrl.sv - cache miss sequencer: dirty-victim write-back, line fetch, single-cycle fill
//   Inputs : clk, rst (async, active-high), i_miss/i_miss_addr, i_victim_dirty/tag/line,
//            i_mem_ack, i_mem_rvalid, i_mem_rdata
//   Outputs: o_mem_req/we/addr/wdata (memory bus), o_fill_valid/o_fill_line, o_busy
//   Optional macro MISS_CTRL_PERF_EN adds o_miss_count and o_wb_count.
module sa_cache_miss_ctrl
  import sa_cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = SA_ADDRESS_WIDTH,
  parameter int TAG_BITS        = SA_TAG_BITS,
  parameter int INDEX_BITS      = SA_INDEX_BITS,
  parameter int OFFSET_BITS     = SA_OFFSET_BITS,
  parameter int LINE_SIZE_BYTES = SA_LINE_SIZE_BYTES,
  parameter int MEM_BUS_BYTES   = SA_MEM_BUS_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss,
  input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
  input  logic                         i_victim_dirty,
  input  logic [TAG_BITS-1:0]          i_victim_tag,
  input  logic [LINE_SIZE_BYTES*8-1:0] i_victim_line,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
  output logic [MEM_BUS_BYTES*8-1:0]   o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic                         i_mem_rvalid,
  input  logic [MEM_BUS_BYTES*8-1:0]   i_mem_rdata,
  output logic                         o_fill_valid,
  output logic [LINE_SIZE_BYTES*8-1:0] o_fill_line,
  output logic                         o_busy
`ifdef MISS_CTRL_PERF_EN
  ,
  output logic [31:0]                  o_miss_count,
  output logic [31:0]                  o_wb_count
`endif
);

  localparam int LINE_BITS = LINE_SIZE_BYTES * 8;
  localparam int BUS_BITS  = MEM_BUS_BYTES * 8;
  localparam int N_BEATS   = LINE_SIZE_BYTES / MEM_BUS_BYTES;
  localparam int CNT_W     = $clog2(N_BEATS);
  localparam int BUS_SHIFT = $clog2(MEM_BUS_BYTES);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  miss_state_t                state_q, state_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic [ADDRESS_WIDTH-1:0]   line_base_q;
  logic [TAG_BITS-1:0]        victim_tag_q;
  logic                       holdoff_q;
  logic [LINE_BITS-1:0]       fill_hold_q;
  logic                       victim_load, fill_wr;
  logic [BUS_BITS-1:0]        victim_beat;
  logic [LINE_BITS-1:0]       fill_line;
  logic [LINE_BITS-1:0]       victim_line_unused;
  logic [BUS_BITS-1:0]        fill_beat_unused;
  logic [OFFSET_BITS-1:0]     miss_offset_unused;
  logic [OFFSET_BITS-1:0]     beat_offset;
  logic [INDEX_BITS-1:0]      line_index;

  assign miss_offset_unused = i_miss_addr[OFFSET_BITS-1:0];
  assign beat_offset        = OFFSET_BITS'(beat_q) << BUS_SHIFT;
  assign line_index         = line_base_q[OFFSET_BITS +: INDEX_BITS];

  line_beat_buffer #(.N_BEATS(N_BEATS), .BEAT_BITS(BUS_BITS)) u_victim_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (victim_load),
    .load_line (i_victim_line),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .rd_idx    (beat_q),
    .rd_data   (victim_beat),
    .line      (victim_line_unused)
  );

  line_beat_buffer #(.N_BEATS(N_BEATS), .BEAT_BITS(BUS_BITS)) u_fill_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b0),
    .load_line ('0),
    .wr_en     (fill_wr),
    .wr_idx    (beat_q),
    .wr_data   (i_mem_rdata),
    .rd_idx    ('0),
    .rd_data   (fill_beat_unused),
    .line      (fill_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      line_base_q  <= '0;
      victim_tag_q <= '0;
      holdoff_q    <= 1'b0;
      fill_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      // The cache drops i_miss on the fill edge, so the first IDLE cycle still sees it high.
      holdoff_q <= (state_q == ST_FILL);
      if (victim_load) begin
        line_base_q  <= {i_miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        victim_tag_q <= i_victim_tag;
      end
      // Keeps the last filled line visible while the fill buffer is reused.
      if (state_q == ST_FILL) fill_hold_q <= fill_line;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_fill_valid = 1'b0;
    victim_load  = 1'b0;
    fill_wr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_miss && !holdoff_q) begin
          victim_load = 1'b1;
          beat_d      = '0;
          state_d     = i_victim_dirty ? ST_WB : ST_RD_REQ;
        end
      end
      ST_WB: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {victim_tag_q, line_index, beat_offset};
        o_mem_wdata = victim_beat;
        if (i_mem_ack) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_RD_REQ;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_RD_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = line_base_q;
        if (i_mem_ack) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (i_mem_rvalid) begin
          fill_wr = 1'b1;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_FILL;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_FILL: begin
        o_fill_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_fill_line = (state_q == ST_FILL) ? fill_line : fill_hold_q;
  assign o_busy      = (state_q != ST_IDLE);

`ifdef MISS_CTRL_PERF_EN
  logic [31:0] miss_count_q, wb_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d != ST_IDLE) miss_count_q <= miss_count_q + 32'd1;
      if (state_q != ST_WB && state_d == ST_WB)     wb_count_q   <= wb_count_q + 32'd1;
    end
  end

  assign o_miss_count = miss_count_q;
  assign o_wb_count   = wb_count_q;
`endif

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// tb/tb_sa_cache_miss_ctrl.sv - scoreboard bench for sa_cache_miss_ctrl
`timescale 1ns/1ps
module tb_sa_cache_miss_ctrl;

  localparam int BEATS = 8;

  typedef struct {
    int           kind;   // 0 write beat, 1 line read, 2 fill
    logic [31:0]  addr;
    logic [63:0]  wdata;
    logic [511:0] line;
    int           lat;    // expected miss-to-fill latency, -1 = not checked
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_miss;
  logic [31:0]  i_miss_addr;
  logic         i_victim_dirty;
  logic [17:0]  i_victim_tag;
  logic [511:0] i_victim_line;
  logic         o_mem_req, o_mem_we;
  logic [31:0]  o_mem_addr;
  logic [63:0]  o_mem_wdata;
  logic         i_mem_ack, i_mem_rvalid;
  logic [63:0]  i_mem_rdata;
  logic         o_fill_valid;
  logic [511:0] o_fill_line;
  logic         o_busy;
`ifdef MISS_CTRL_PERF_EN
  logic [31:0]  o_miss_count, o_wb_count;
`endif

  sa_cache_miss_ctrl dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_victim_dirty(i_victim_dirty), .i_victim_tag(i_victim_tag), .i_victim_line(i_victim_line),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_fill_valid(o_fill_valid), .o_fill_line(o_fill_line), .o_busy(o_busy)
`ifdef MISS_CTRL_PERF_EN
    , .o_miss_count(o_miss_count), .o_wb_count(o_wb_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  exp_t exp_q[$];

  // memory-model controls
  logic [511:0] rd_src;
  int  rd_left, rd_idx, waited;
  int  stall_wb_beat = -1;
  bit  stall_rd = 0;
  bit  spur_ack = 0, spur_rvalid = 0;

  task automatic check_eq(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder: decisions are made #1 after the edge from the post-edge request.
  initial begin
    bit hs_rd, rv_take, stall_now;
    i_mem_ack = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    rd_left = 0; rd_idx = 0; waited = 0;
    forever begin
      @(negedge clk);
      hs_rd   = o_mem_req && !o_mem_we && i_mem_ack;
      rv_take = i_mem_rvalid && (rd_left > 0);
      @(posedge clk); #1;
      if (rst) begin
        rd_left = 0; rd_idx = 0; waited = 0;
        i_mem_ack = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
      end else begin
        if (hs_rd) begin rd_left = BEATS; rd_idx = 0; end
        else if (rv_take) begin rd_left--; rd_idx++; end
        if (o_mem_req) begin
          stall_now = (o_mem_we && (int'(o_mem_addr[5:3]) == stall_wb_beat)) || (!o_mem_we && stall_rd);
          if (stall_now && waited < 5) begin i_mem_ack = 0; waited++; end
          else begin i_mem_ack = 1; waited = 0; end
        end else begin
          i_mem_ack = spur_ack;
        end
        if (rd_left > 0) begin
          i_mem_rvalid = 1; i_mem_rdata = rd_src[rd_idx*64 +: 64];
        end else begin
          i_mem_rvalid = spur_rvalid; i_mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a request or fills.
  initial begin
    exp_t e;
    bit prev_req = 0, prev_ack = 0, prev_we = 0, busy_prev = 0;
    logic [31:0] prev_addr;
    logic [63:0] prev_wdata;
    int miss_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 0; prev_ack = 0; busy_prev = 0;
      end else begin
        if (o_busy && !busy_prev) miss_cyc = cyc;
        if (o_mem_req && prev_req && !prev_ack) begin
          check_eq("stall_addr_stable", o_mem_addr, prev_addr);
          check_eq("stall_we_stable", o_mem_we, prev_we);
          check_eq("stall_wdata_stable", o_mem_wdata, prev_wdata);
        end
        if (o_mem_req && i_mem_ack) begin
          if (exp_q.size() == 0) check_eq("unexpected_mem_req", o_mem_addr, 512'hx);
          else begin
            e = exp_q.pop_front();
            check_eq("req_kind", o_mem_we ? 0 : 1, e.kind);
            check_eq("req_addr", o_mem_addr, e.addr);
            if (e.kind == 0) check_eq("wb_wdata", o_mem_wdata, e.wdata);
          end
        end
        if (o_fill_valid) begin
          if (exp_q.size() == 0) check_eq("unexpected_fill", o_fill_line, 512'hx);
          else begin
            e = exp_q.pop_front();
            check_eq("fill_kind", 2, e.kind);
            check_eq("fill_line", o_fill_line, e.line);
            if (e.lat >= 0) check_eq("fill_latency", cyc + 1 - miss_cyc, e.lat);
          end
        end
        prev_req = o_mem_req; prev_ack = i_mem_ack; prev_we = o_mem_we;
        prev_addr = o_mem_addr; prev_wdata = o_mem_wdata;
        busy_prev = o_busy;
      end
    end
  end

  function automatic logic [511:0] mk_line(input logic [63:0] hi);
    logic [511:0] l;
    for (int k = 0; k < BEATS; k++) l[k*64 +: 64] = hi | 64'(k);
    return l;
  endfunction

  task automatic push_exp(input int kind, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [511:0] line, input int lat);
    exp_t e;
    e.kind = kind; e.addr = addr; e.wdata = wd; e.line = line; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // wb_base / rd_base are the hand-computed write-back and line-read addresses.
  task automatic run_miss(input logic [31:0] addr, input bit dirty, input logic [17:0] vtag,
                          input logic [511:0] vline, input logic [511:0] rline,
                          input logic [31:0] wb_base, input logic [31:0] rd_base,
                          input int lat, input int extra_hold);
    bit seen = 0;
    if (dirty)
      for (int k = 0; k < BEATS; k++) push_exp(0, wb_base + 32'(8*k), vline[k*64 +: 64], '0, -1);
    push_exp(1, rd_base, '0, '0, -1);
    push_exp(2, '0, '0, rline, lat);
    rd_src = rline;
    i_miss_addr = addr; i_victim_dirty = dirty; i_victim_tag = vtag; i_victim_line = vline;
    i_miss = 1;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (o_fill_valid) seen = 1;
    end
    if (!seen) check_eq("fill_timeout", 0, 1);
    @(posedge clk); #1;
    repeat (extra_hold) begin @(posedge clk); #1; end
    i_miss = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] l_a, l_b, l_c, l_d, l_e;
    bit hit;
    rst = 1; i_miss = 0; i_miss_addr = '0; i_victim_dirty = 0; i_victim_tag = '0; i_victim_line = '0;
    rd_src = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_mem_req", o_mem_req, 0);
    check_eq("rst_mem_we", o_mem_we, 0);
    check_eq("rst_mem_addr", o_mem_addr, 0);
    check_eq("rst_mem_wdata", o_mem_wdata, 0);
    check_eq("rst_fill_valid", o_fill_valid, 0);
    check_eq("rst_fill_line", o_fill_line, 0);
    rst = 0;
    @(posedge clk); #1;

    // clean miss, immediate responses, beat k = k
    l_a = mk_line(64'h0);
    run_miss(32'h0000_1240, 0, '0, '0, l_a, 32'h0, 32'h0000_1240, 10, 0);

    // dirty miss: victim tag 3, index 0x49, requested tag 5
    l_b = mk_line(64'hC0DE_0000_0000_0000);
    l_c = mk_line(64'h0000_0000_0000_F000);
    run_miss(32'h0001_5250, 1, 18'h3, l_b, l_c, 32'h0000_D240, 32'h0001_5240, -1, 0);

    // ack withheld 5 cycles on WB beat 3 and on the line read
    stall_wb_beat = 3; stall_rd = 1;
    l_d = mk_line(64'h5A5A_0000_1111_0000);
    run_miss(32'h0001_5250, 1, 18'h3, l_c, l_d, 32'h0000_D240, 32'h0001_5240, -1, 0);
    stall_wb_beat = -1; stall_rd = 0;

    // spurious rvalid in IDLE/WB/RD_REQ and spurious ack in IDLE/RD_DATA
    spur_ack = 1; spur_rvalid = 1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("spur_idle_busy", o_busy, 0);
    check_eq("spur_idle_fill_hold", o_fill_line, l_d);
    l_e = mk_line(64'h7700_0000_0000_0000);
    run_miss(32'h0000_D27F, 1, 18'h2A, l_a, l_e, 32'h000A_9240, 32'h0000_D240, -1, 0);
    spur_ack = 0; spur_rvalid = 0;

    // reset in RD_DATA after four beats
    push_exp(1, 32'h0000_0080, '0, '0, -1);
    rd_src = l_b;
    i_miss_addr = 32'h0000_0088; i_victim_dirty = 0; i_miss = 1;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #2;
      if (rd_idx == 4 && rd_left > 0) hit = 1;
    end
    if (!hit) check_eq("rd_beat4_timeout", 0, 1);
    rst = 1; i_miss = 0;
    #1;
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_mem_req", o_mem_req, 0);
    check_eq("midrst_mem_addr", o_mem_addr, 0);
    check_eq("midrst_fill_line", o_fill_line, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    check_eq("post_rst_busy", o_busy, 0);
    run_miss(32'h0000_0088, 0, '0, '0, l_c, 32'h0, 32'h0000_0080, 10, 0);

    // miss held one cycle past the fill: must not retrigger
    run_miss(32'h00FF_FFC4, 0, '0, '0, l_e, 32'h0, 32'h00FF_FFC0, 10, 1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("hold_no_retrigger_busy", o_busy, 0);
    check_eq("hold_fill_line_kept", o_fill_line, l_e);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
